// File: rtl/spi_nvm_emu.sv
// SPI mode-0 serial EEPROM emulator: READ/WRITE/RDSR/WRSR/WREN/WRDI with block protection,
// emulated write-busy time and a host backdoor load port. SPI pins are oversampled in clk.
module spi_nvm_emu #(
    parameter int ADDR_BYTES = 2,
    parameter int DEPTH      = 8192,
    parameter int PAGE       = 32,
    parameter int WR_CYCLES  = 1000,
    parameter int SYNC       = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cs_n,
    input  logic                     sck,
    input  logic                     si,
    output logic                     so,
    input  logic                     ld_en,
    input  logic [$clog2(DEPTH)-1:0] ld_addr,
    input  logic [7:0]               ld_data,
    output logic                     busy
);
    localparam int AW    = $clog2(DEPTH);
    localparam int ABITS = 8 * ADDR_BYTES;
    localparam int CW    = $clog2(WR_CYCLES + 1);
    localparam logic [AW-1:0] PMASK  = AW'(PAGE - 1);
    localparam logic [AW:0]   HALF_A = (AW+1)'(DEPTH / 2);
    localparam logic [AW:0]   QTR_A  = (AW+1)'(DEPTH - DEPTH / 4);

    typedef enum logic [2:0] {S_IDLE, S_CMD, S_ADDR, S_RD, S_SR, S_WR, S_SW, S_IGN} state_t;

    logic [SYNC-1:0]  cs_q, sck_q, si_q;
    logic             cs_d, sck_d;
    state_t           state;
    logic [4:0]       bit_cnt;
    logic [2:0]       obit;
    logic [ABITS-1:0] shreg;
    logic [7:0]       osr, rd_q;
    logic [AW-1:0]    addr;
    logic             is_wr, wel, got_byte;
    logic [1:0]       bp, bp_new;
    logic [CW-1:0]    wip_cnt;
    logic [7:0]       mem [DEPTH];

    logic cs_s, sck_s, si_s, sck_rise, sck_fall, cs_rise, cs_fall;
    logic wip, byte_end, wr_done, sw_done, commit, prot, spi_we, mem_we;
    logic [ABITS-1:0] sh_next;
    logic [AW-1:0]    addr_pinc, mem_wa;
    logic [7:0]       mem_wd, status, out_byte;
    logic             unused_bits;

    assign cs_s  = cs_q[SYNC-1];
    assign sck_s = sck_q[SYNC-1];
    assign si_s  = si_q[SYNC-1];
    // sck rise is qualified by the previous cs state so a final rise coinciding with cs rise still lands
    assign sck_rise = sck_s & ~sck_d & ~cs_d;
    assign sck_fall = ~sck_s & sck_d & ~cs_s;
    assign cs_rise  = cs_s & ~cs_d;
    assign cs_fall  = ~cs_s & cs_d;

    assign sh_next   = {shreg[ABITS-2:0], si_s};
    assign unused_bits = ^sh_next;
    assign wip       = (wip_cnt != '0);
    assign busy      = wip;
    assign status    = {4'b0, bp, wel, wip};
    assign out_byte  = (state == S_RD) ? rd_q : status;
    assign byte_end  = sck_rise && (bit_cnt == 5'd7);
    assign wr_done   = byte_end && (state == S_WR);
    assign sw_done   = byte_end && (state == S_SW);
    assign commit    = cs_rise && (state == S_WR || state == S_SW) && (got_byte || wr_done || sw_done);
    assign addr_pinc = (addr & ~PMASK) | ((addr + 1'b1) & PMASK);
    assign prot      = (bp == 2'b11) || (bp == 2'b10 && {1'b0, addr} >= HALF_A)
                       || (bp == 2'b01 && {1'b0, addr} >= QTR_A);
    assign spi_we    = wr_done && !prot;
    assign mem_we    = spi_we || (ld_en && cs_s && cs_d && !wip);
    assign mem_wa    = spi_we ? addr : ld_addr;
    assign mem_wd    = spi_we ? sh_next[7:0] : ld_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs_q  <= '1;
            sck_q <= '0;
            si_q  <= '0;
            cs_d  <= 1'b1;
            sck_d <= 1'b0;
        end else begin
            cs_q  <= {cs_q[SYNC-2:0], cs_n};
            sck_q <= {sck_q[SYNC-2:0], sck};
            si_q  <= {si_q[SYNC-2:0], si};
            cs_d  <= cs_s;
            sck_d <= sck_s;
        end
    end

    // No reset: contents survive rst_n and are only changed by SPI writes or the backdoor
    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_wa] <= mem_wd;
        rd_q <= mem[addr];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            bit_cnt  <= '0;
            obit     <= '0;
            shreg    <= '0;
            osr      <= '0;
            addr     <= '0;
            is_wr    <= 1'b0;
            wel      <= 1'b0;
            got_byte <= 1'b0;
            bp       <= 2'b00;
            bp_new   <= 2'b00;
            wip_cnt  <= '0;
            so       <= 1'b1;
        end else begin
            if (wip) wip_cnt <= wip_cnt - 1'b1;
            if (cs_fall) begin
                state   <= S_CMD;
                bit_cnt <= '0;
            end
            if (sck_rise) begin
                shreg   <= sh_next;
                bit_cnt <= bit_cnt + 1'b1;
                case (state)
                    S_CMD: if (bit_cnt == 5'd7) begin
                        bit_cnt  <= '0;
                        obit     <= '0;
                        got_byte <= 1'b0;
                        if (wip && sh_next[7:0] != 8'h05) state <= S_IGN;
                        else begin
                            case (sh_next[7:0])
                                8'h03: begin state <= S_ADDR; is_wr <= 1'b0; end
                                8'h02: begin state <= wel ? S_ADDR : S_IGN; is_wr <= 1'b1; end
                                8'h05: state <= S_SR;
                                8'h01: state <= wel ? S_SW : S_IGN;
                                8'h06: begin wel <= 1'b1; state <= S_IGN; end
                                8'h04: begin wel <= 1'b0; state <= S_IGN; end
                                default: state <= S_IGN;
                            endcase
                        end
                    end
                    S_ADDR: if (bit_cnt == 5'(ABITS - 1)) begin
                        bit_cnt <= '0;
                        addr    <= sh_next[AW-1:0];
                        state   <= is_wr ? S_WR : S_RD;
                    end
                    S_WR: if (bit_cnt == 5'd7) begin
                        bit_cnt  <= '0;
                        addr     <= addr_pinc;
                        got_byte <= 1'b1;
                    end
                    S_SW: if (bit_cnt == 5'd7) begin
                        bit_cnt  <= '0;
                        got_byte <= 1'b1;
                        if (!got_byte) bp_new <= sh_next[3:2];
                    end
                    default: ;
                endcase
            end
            if (sck_fall && (state == S_RD || state == S_SR)) begin
                obit <= obit + 1'b1;
                if (obit == 3'd0) begin
                    so  <= out_byte[7];
                    osr <= {out_byte[6:0], 1'b0};
                    if (state == S_RD) addr <= addr + 1'b1;
                end else begin
                    so  <= osr[7];
                    osr <= {osr[6:0], 1'b0};
                end
            end
            if (cs_rise) begin
                state   <= S_IDLE;
                bit_cnt <= '0;
                so      <= 1'b1;
                if (commit) begin
                    wel     <= 1'b0;
                    wip_cnt <= CW'(WR_CYCLES);
                    if (state == S_SW) bp <= (sw_done && !got_byte) ? sh_next[3:2] : bp_new;
                end
            end
        end
    end
endmodule

// File: tb/tb_spi_nvm_emu.sv
// Directed bench for spi_nvm_emu: SPI transactions driven bit by bit, expected bytes hand-computed.
module tb_spi_nvm_emu;
    localparam int HALF = 80;

    logic        clk = 0, rst_n = 0, cs_n = 1, sck = 0, si = 0, ld_en = 0;
    logic [12:0] ld_addr = '0;
    logic [7:0]  ld_data = '0;
    logic        so, busy;
    int          n_chk = 0, n_pass = 0;

    always #5 clk = ~clk;

    spi_nvm_emu dut (
        .clk(clk), .rst_n(rst_n), .cs_n(cs_n), .sck(sck), .si(si), .so(so),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data), .busy(busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        rx = '0;
        for (int i = 0; i < nbits; i++) begin
            si = tx[7-i];
            #(HALF);
            rx = {rx[6:0], so};
            sck = 1;
            #(HALF);
            sck = 0;
        end
    endtask

    task automatic cs_lo();
        cs_n = 0;
        #(HALF);
    endtask

    task automatic cs_hi();
        #(HALF);
        cs_n = 1;
        #(4*HALF);
    endtask

    task automatic op(input logic [7:0] c);
        logic [7:0] d;
        cs_lo(); xfer(c, 8, d); cs_hi();
    endtask

    task automatic rdsr(input string tag, input logic [7:0] exp);
        logic [7:0] d;
        cs_lo(); xfer(8'h05, 8, d); xfer(8'h00, 8, d); cs_hi();
        chk(tag, d, exp);
    endtask

    task automatic send3(input logic [7:0] c, input logic [15:0] a);
        logic [7:0] d;
        cs_lo(); xfer(c, 8, d); xfer(a[15:8], 8, d); xfer(a[7:0], 8, d);
    endtask

    task automatic rd_byte(input string tag, input logic [7:0] exp);
        logic [7:0] d;
        xfer(8'h00, 8, d);
        chk(tag, d, exp);
    endtask

    task automatic wr_byte(input logic [7:0] b);
        logic [7:0] d;
        xfer(b, 8, d);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy === 1'b1 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk(tag, busy, 1'b0);
        @(negedge clk);
        #2;
    endtask

    initial begin
        #(5000000);
        $display("FAIL watchdog: run did not end, checks %0d", n_chk);
        $fatal(1);
    end

    initial begin
        logic [7:0] d;
        int n;
        #22 rst_n = 1;
        #20;
        chk("rst_so", so, 1'b1);
        chk("rst_busy", busy, 1'b0);
        rdsr("rst_status", 8'h00);

        for (int i = 0; i < 8192; i++) begin
            @(negedge clk);
            ld_addr = 13'(i); ld_data = 8'(i); ld_en = 1;
        end
        @(negedge clk);
        ld_en = 0;
        #2;

        // backdoor load while cs_n low must be dropped
        cs_n = 0;
        #100;
        @(negedge clk);
        ld_addr = 13'h0040; ld_data = 8'hEE; ld_en = 1;
        @(negedge clk);
        ld_en = 0;
        #2;
        cs_n = 1;
        #(4*HALF);

        send3(8'h03, 16'h1FFD);
        rd_byte("rd_1ffd", 8'hFD); rd_byte("rd_1ffe", 8'hFE); rd_byte("rd_1fff", 8'hFF);
        rd_byte("rd_wrap0", 8'h00); rd_byte("rd_wrap1", 8'h01); rd_byte("rd_wrap2", 8'h02);
        cs_hi();
        send3(8'h03, 16'h0040);
        rd_byte("ld_cs_low_drop", 8'h40); rd_byte("rd_41", 8'h41);
        cs_hi();

        send3(8'h02, 16'h0010); wr_byte(8'hAA); cs_hi();
        rdsr("nowel_status", 8'h00);
        chk("nowel_busy", busy, 1'b0);
        send3(8'h03, 16'h0010); rd_byte("nowel_mem", 8'h10); cs_hi();

        op(8'h06);
        rdsr("wel_set", 8'h02);
        send3(8'h02, 16'h001E); wr_byte(8'h11); wr_byte(8'h22); wr_byte(8'h33); cs_hi();
        rdsr("wip_after_write", 8'h01);
        chk("busy_after_write", busy, 1'b1);
        @(negedge clk);
        ld_addr = 13'h0041; ld_data = 8'hEE; ld_en = 1;
        @(negedge clk);
        ld_en = 0;
        #2;
        op(8'h06);
        wait_idle("write_wip_clear");
        rdsr("wren_ignored_wip", 8'h00);
        send3(8'h03, 16'h001E);
        rd_byte("pg_1e", 8'h11); rd_byte("pg_1f", 8'h22); rd_byte("pg_20_untouched", 8'h20);
        cs_hi();
        send3(8'h03, 16'h0000); rd_byte("pg_wrap_00", 8'h33); rd_byte("pg_01", 8'h01); cs_hi();
        send3(8'h03, 16'h0041); rd_byte("ld_wip_drop", 8'h41); cs_hi();

        // WRSR with exact WIP length measured from the cs_n rise
        op(8'h06);
        cs_lo(); xfer(8'h01, 8, d); xfer(8'h0C, 8, d);
        #(HALF);
        cs_n = 1;
        n = 0;
        while (n < 2000) begin
            @(negedge clk);
            n++;
            if (n > 10 && busy == 1'b0) break;
        end
        #2;
        chk("wip_len", n, 1003);
        #(4*HALF);
        rdsr("bp_set", 8'h0C);
        op(8'h06);
        rdsr("wel_bp", 8'h0E);
        send3(8'h02, 16'h0005); wr_byte(8'h55); cs_hi();
        rdsr("wip_protected", 8'h0D);
        wait_idle("prot_wip_clear");
        send3(8'h03, 16'h0005); rd_byte("prot_unchanged", 8'h05); cs_hi();
        op(8'h06);
        cs_lo(); xfer(8'h01, 8, d); xfer(8'h00, 8, d); cs_hi();
        wait_idle("bp_clr_wip");
        rdsr("bp_clear", 8'h00);

        // aborted transfers
        cs_lo(); xfer(8'h03, 4, d); cs_hi();
        chk("abort_so", so, 1'b1);
        op(8'h06);
        send3(8'h02, 16'h0020); xfer(8'hFF, 4, d); cs_hi();
        chk("partial_busy", busy, 1'b0);
        rdsr("partial_wel_kept", 8'h02);
        send3(8'h03, 16'h0020); rd_byte("partial_mem", 8'h20); rd_byte("partial_mem21", 8'h21); cs_hi();

        // final sck rise coincides with cs_n rise: byte lands, then commit
        send3(8'h02, 16'h0030);
        xfer(8'h77, 7, d);
        si = 1'b1;
        #(HALF);
        sck = 1; cs_n = 1;
        #(HALF);
        sck = 0;
        #(4*HALF);
        chk("simul_busy", busy, 1'b1);
        wait_idle("simul_wip_clear");
        rdsr("simul_status", 8'h00);
        send3(8'h03, 16'h0030); rd_byte("simul_mem", 8'h77); cs_hi();

        // reset in the middle of a READ
        op(8'h06);
        send3(8'h03, 16'h001E);
        rd_byte("pre_rst_rd", 8'h11);
        xfer(8'h00, 3, d);
        rst_n = 0;
        #40;
        chk("midrst_so", so, 1'b1);
        chk("midrst_busy", busy, 1'b0);
        rst_n = 1;
        #40;
        cs_n = 1;
        #(4*HALF);
        rdsr("midrst_status", 8'h00);
        send3(8'h03, 16'h001E); rd_byte("midrst_mem", 8'h11); cs_hi();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
